// File: rtl/axi_ram_responder.sv
// AXI4 slave terminating one crossbar master port with a local byte-addressable RAM.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst per direction.
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 8
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 1
`endif

module axi_ram_responder #(
  parameter int DATA_WIDTH     = `HACD_AXI4_DATA_WIDTH,
  parameter int ADDR_WIDTH     = `HACD_AXI4_ADDR_WIDTH,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH       = `HACD_AXI4_ID_WIDTH,
  parameter int USER_WIDTH     = `HACD_AXI4_USER_WIDTH,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic [USER_WIDTH-1:0] s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic [USER_WIDTH-1:0] s_axi_buser,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [USER_WIDTH-1:0] s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic [USER_WIDTH-1:0] s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = MEM_ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH    = 2 ** IDX_W;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    if (s > 3'(ADDR_LSB)) return 3'(ADDR_LSB);
    return s;
  endfunction

  // FIXED holds the address; INCR, WRAP and reserved types all step by the size.
  function automatic logic [MEM_ADDR_WIDTH-1:0] next_addr(input logic [MEM_ADDR_WIDTH-1:0] a,
                                                          input logic [2:0] size,
                                                          input logic [1:0] burst);
    logic [MEM_ADDR_WIDTH-1:0] step;
    step = MEM_ADDR_WIDTH'(1) << size;
    if (burst == 2'b00) return a;
    return (a & ~(step - 1'b1)) + step;
  endfunction

  w_state_t                  w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]       aw_id_q, aw_id_d;
  logic [MEM_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [7:0]                aw_len_q, aw_len_d;
  logic [2:0]                aw_size_q, aw_size_d;
  logic [1:0]                aw_burst_q, aw_burst_d;
  logic [7:0]                w_cnt_q, w_cnt_d;
  logic                      w_err_q, w_err_d;
  logic                      mem_we;
  logic                      w_final;

  always_comb begin
    w_state_d  = w_state_q;
    aw_id_d    = aw_id_q;
    aw_addr_d  = aw_addr_q;
    aw_len_d   = aw_len_q;
    aw_size_d  = aw_size_q;
    aw_burst_d = aw_burst_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    mem_we     = 1'b0;
    w_final    = (w_cnt_q == aw_len_q);
    unique case (w_state_q)
      W_IDLE: if (s_axi_awvalid) begin
        aw_id_d    = s_axi_awid;
        aw_addr_d  = s_axi_awaddr[MEM_ADDR_WIDTH-1:0];
        aw_len_d   = s_axi_awlen;
        aw_size_d  = clamp_size(s_axi_awsize);
        aw_burst_d = s_axi_awburst;
        w_cnt_d    = '0;
        w_err_d    = 1'b0;
        w_state_d  = W_DATA;
      end
      // Beat count alone ends the burst; a misplaced wlast only flags SLVERR.
      W_DATA: if (s_axi_wvalid) begin
        mem_we = 1'b1;
        if (s_axi_wlast != w_final) w_err_d = 1'b1;
        if (w_final) begin
          w_state_d = W_RESP;
        end else begin
          w_cnt_d   = w_cnt_q + 8'd1;
          aw_addr_d = next_addr(aw_addr_q, aw_size_q, aw_burst_q);
        end
      end
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      aw_id_q    <= aw_id_d;
      aw_addr_q  <= aw_addr_d;
      aw_len_q   <= aw_len_d;
      aw_size_q  <= aw_size_d;
      aw_burst_q <= aw_burst_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
        if (s_axi_wstrb[i]) mem[aw_addr_q[MEM_ADDR_WIDTH-1:ADDR_LSB]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = aw_id_q;
  assign s_axi_bresp   = w_err_q ? 2'b10 : 2'b00;
  assign s_axi_buser   = '0;

  r_state_t                  r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]       ar_id_q, ar_id_d;
  logic [MEM_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]                ar_len_q, ar_len_d;
  logic [2:0]                ar_size_q, ar_size_d;
  logic [1:0]                ar_burst_q, ar_burst_d;
  logic [7:0]                r_cnt_q, r_cnt_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      rlast_q, rlast_d;

  always_comb begin
    r_state_d  = r_state_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    r_cnt_d    = r_cnt_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    unique case (r_state_q)
      R_IDLE: if (s_axi_arvalid) begin
        ar_id_d    = s_axi_arid;
        ar_addr_d  = s_axi_araddr[MEM_ADDR_WIDTH-1:0];
        ar_len_d   = s_axi_arlen;
        ar_size_d  = clamp_size(s_axi_arsize);
        ar_burst_d = s_axi_arburst;
        r_cnt_d    = '0;
        r_state_d  = R_READ;
      end
      R_READ: begin
        rdata_d   = mem[ar_addr_q[MEM_ADDR_WIDTH-1:ADDR_LSB]];
        rlast_d   = (r_cnt_q == ar_len_q);
        r_state_d = R_DATA;
      end
      R_DATA: if (s_axi_rready) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          r_cnt_d   = r_cnt_q + 8'd1;
          ar_addr_d = next_addr(ar_addr_q, ar_size_q, ar_burst_q);
          r_state_d = R_READ;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      rdata_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
      r_cnt_q    <= r_cnt_d;
      rdata_q    <= rdata_d;
      rlast_q    <= rlast_d;
    end
  end

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = ar_id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_ruser   = '0;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH], s_axi_awlock, s_axi_awcache,
                       s_axi_awprot, s_axi_awqos, s_axi_awuser,
                       s_axi_araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH], s_axi_arlock, s_axi_arcache,
                       s_axi_arprot, s_axi_arqos, s_axi_aruser};

endmodule

// File: doc/axi_ram_responder.md
Name: axi_ram_responder

Overview:
- AXI4 slave (responder) that terminates one master port of the HACD AXI crossbar with a local byte-addressable RAM.
- Used as a scratch/metadata store and as the crossbar's end-to-end verification target.
- Independent write and read state machines, one outstanding transaction per direction.
- Supports INCR and FIXED bursts with byte strobes; AW/W/B and AR/R run concurrently.

Parameters:
DATA_WIDTH, `HACD_AXI4_DATA_WIDTH, data bus width in bits (power of two, >= 32)
ADDR_WIDTH, `HACD_AXI4_ADDR_WIDTH, AXI address width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
ID_WIDTH, `HACD_AXI4_ID_WIDTH, ID width; matches crossbar M_ID_WIDTH
USER_WIDTH, `HACD_AXI4_USER_WIDTH, width of buser/ruser (driven 0)
MEM_ADDR_WIDTH, 12, byte-address bits decoded; depth = 2^MEM_ADDR_WIDTH/STRB_WIDTH words

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  asynchronous active-high reset
s_axi_awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2  write address fields
s_axi_awvalid  input  1;  s_axi_awready  output  1  AW handshake
s_axi_wdata/wstrb/wlast  input  DATA_WIDTH/STRB_WIDTH/1  write data;  s_axi_wvalid input 1;  s_axi_wready output 1
s_axi_bid/bresp/buser  output  ID_WIDTH/2/USER_WIDTH;  s_axi_bvalid output 1;  s_axi_bready input 1
s_axi_arid/araddr/arlen/arsize/arburst  input  ID_WIDTH/ADDR_WIDTH/8/3/2;  s_axi_arvalid input 1;  s_axi_arready output 1
s_axi_rid/rdata/rresp/rlast/ruser  output  ID_WIDTH/DATA_WIDTH/2/1/USER_WIDTH;  s_axi_rvalid output 1;  s_axi_rready input 1
(awlock/awcache/awprot/awqos/awuser and AR equivalents present as inputs, ignored.)

Behaviour:
- Reset (async assert, released on clk): both FSMs to IDLE. awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0, bid=rid=0, rdata=0. RAM contents are not reset. Reset mid-burst abandons the burst; no B/R is produced afterwards.
- Word index = addr[MEM_ADDR_WIDTH-1:log2(STRB_WIDTH)]. Upper address bits are ignored, so accesses alias modulo RAM size.
- Effective size = min(axsize, log2(STRB_WIDTH)).
- Next-address rules:
  - INCR: next = (addr & ~(2^size-1)) + 2^size, modulo 2^MEM_ADDR_WIDTH.
  - FIXED: address held.
  - WRAP and reserved burst types are treated as INCR.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake capture id/addr/len/size/burst, clear beat counter and error flag; next W_IDLE->W_DATA, awready=0, wready=1.
  - W_DATA: each W handshake writes lanes with wstrb=1 at the current word and advances the address.
  - wlast mismatch (wlast=1 with counter!=len, or wlast=0 with counter==len) sets the error flag.
  - The burst always ends after exactly len+1 beats. On the final beat go to W_RESP: wready=0, bvalid=1, bid=captured id, bresp=2'b10 if error else 2'b00.
  - W_RESP: hold bvalid/bid/bresp stable until bready, then go to W_IDLE with awready=1 next cycle.
  - No new AW is accepted before the B handshake.
- Read FSM R_IDLE -> R_READ -> R_DATA:
  - R_IDLE: arready=1. On AR handshake capture fields; go to R_READ, arready=0.
  - R_READ: registered RAM read of the current word into rdata. Set rvalid=1, rid=captured id, rresp=0, rlast=(counter==len). Go to R_DATA.
  - R_DATA: hold all R outputs stable while rvalid && !rready. On handshake: if rlast, go to R_IDLE with rvalid=0, arready=1; else advance address/counter, rvalid=0, go to R_READ.
  - Latency: first rvalid 2 cycles after the AR handshake cycle; throughput 1 beat per 2 cycles.
- Same-edge write and read of the same word: read returns the old data (read-before-write).
- buser, ruser = 0 always.

Test Plan:
- Backdoor RAM all zero, DATA_WIDTH=64. INCR write awid=5, addr 0x100, len=3, size=3, data 0x11..11/0x22..22/0x33..33/0x44..44 -> bresp=0, bid=5. Read arid=7 same burst -> 4 beats in order, rid=7, rlast only on beat 4.
- Write addr 0x200, len=0, data all-ones, wstrb=0x0F onto zeroed word -> read 0x200 returns 0x00000000FFFFFFFF.
- FIXED write addr 0x300, len=2, data A,B,C -> single read at 0x300 returns C; 0x308 unchanged.
- Write len=3 with wlast on beat 2 -> all 4 beats accepted (wready high through beat 4), bresp=2'b10.
- Backpressure:
  - bready=0 for 10 cycles -> bvalid and bid stable, awready=0 throughout.
  - rready toggled 0/1 -> rdata/rlast stable while stalled; no beats lost or duplicated.
- Assert rst during R_DATA beat 2 of len=3 -> rvalid=0 immediately; after release arready=1; new read returns correct data.
